// File: rtl/alu_reg_file.sv
// rtl/alu_reg_file.sv - ALU register file with status flags; optional write-through forwarding via ALU_REG_FILE_BYPASS_EN
module alu_reg_file #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              rd_we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              flag_we,
    input  logic              z_f_in,
    input  logic              o_f_in,
    output logic              z_flag,
    output logic              o_flag,
    output logic [15:0]       wr_count
);

    // Index width of the implemented storage; upper address bits only take part in range checks.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_z_flag;
    logic              r_o_flag;
    logic [15:0]       r_wr_count;

    logic              w_wr_ok;
    logic [IDX_W-1:0]  w_wr_idx;

    // An address holds real storage only if it is implemented and not the hardwired zero register.
    function automatic logic f_addr_live(input logic [ADDR_W-1:0] addr);
        logic live;
        live = (32'(addr) < NUM_REGS);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            live = 1'b0;
        end
        return live;
    endfunction

    // Stored value at an address, zero for dead addresses.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (f_addr_live(addr)) begin
            val = r_regs[addr[IDX_W-1:0]];
        end
        return val;
    endfunction

    assign w_wr_ok  = rd_we && f_addr_live(rd_addr);
    assign w_wr_idx = rd_addr[IDX_W-1:0];

    // Register array and commit counter; discarded writes leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_ok) begin
            r_regs[w_wr_idx] <= rd_data;
            r_wr_count       <= r_wr_count + 16'd1;
        end
    end

    // Status flags captured from the ALU for later branch decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_flag <= 1'b0;
            r_o_flag <= 1'b0;
        end else if (flag_we) begin
            r_z_flag <= z_f_in;
            r_o_flag <= o_f_in;
        end
    end

`ifdef ALU_REG_FILE_BYPASS_EN
    // Combinational read ports with per-port forwarding of a committable same-cycle write.
    always_comb begin
        rs1_data = f_read(rs1_addr);
        rs2_data = f_read(rs2_addr);
        if (w_wr_ok && (rs1_addr == rd_addr)) begin
            rs1_data = rd_data;
        end
        if (w_wr_ok && (rs2_addr == rd_addr)) begin
            rs2_data = rd_data;
        end
    end
`else
    // Combinational read ports returning stored values only.
    always_comb begin
        rs1_data = f_read(rs1_addr);
        rs2_data = f_read(rs2_addr);
    end
`endif

    assign z_flag   = r_z_flag;
    assign o_flag   = r_o_flag;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_alu_reg_file.sv
// tb/tb_alu_reg_file.sv - directed self-checking bench for alu_reg_file
module tb_alu_reg_file;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rd_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              flag_we;
    logic              z_f_in;
    logic              o_f_in;
    logic              z_flag;
    logic              o_flag;
    logic [15:0]       wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [DATA_W-1:0] exp_fwd;

    alu_reg_file #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .flag_we(flag_we), .z_f_in(z_f_in), .o_f_in(o_f_in),
        .z_flag(z_flag), .o_flag(o_flag), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rd_we   = 1'b1;
        rd_addr = a;
        rd_data = d;
        @(posedge clk);
        #1;
        rd_we = 1'b0;
        if (a < 32 && a != 0) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic rd2(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_we = 1'b0; rd_addr = '0;
        rd_data = '0; flag_we = 1'b0; z_f_in = 1'b0; o_f_in = 1'b0;
        repeat (2) @(posedge clk);
        rd2(6'd5, 6'd5);
        check("rst_hold_rd", rs1_data, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            rd2(ADDR_W'(i), ADDR_W'(31 - i));
            check("rst_rs1", rs1_data, 64'd0);
            check("rst_rs2", rs2_data, 64'd0);
        end
        check("rst_z", {63'd0, z_flag}, 64'd0);
        check("rst_o", {63'd0, o_flag}, 64'd0);
        check("rst_cnt", {48'd0, wr_count}, 64'd0);

        wr(6'd5, 64'h0000_0000_DEAD_BEEF);
        rd2(6'd5, 6'd5);
        check("r5_rs1", rs1_data, 64'h0000_0000_DEAD_BEEF);
        check("r5_rs2", rs2_data, 64'h0000_0000_DEAD_BEEF);
        check("cnt_1", {48'd0, wr_count}, 64'd1);

        wr(6'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd2(6'd0, 6'd0);
        check("r0_rs1", rs1_data, 64'd0);
        check("r0_rs2", rs2_data, 64'd0);
        check("cnt_r0", {48'd0, wr_count}, {48'd0, exp_cnt});

        wr(6'd40, 64'h1111_2222_3333_4444);
        rd2(6'd40, 6'd8);
        check("r40_rd", rs1_data, 64'd0);
        check("r8_alias", rs2_data, 64'd0);
        check("cnt_r40", {48'd0, wr_count}, {48'd0, exp_cnt});

        wr(6'd31, 64'hA5A5_0000_0000_0031);
        wr(6'd1,  64'h0000_0000_0000_0001);
        rd2(6'd31, 6'd1);
        check("r31", rs1_data, 64'hA5A5_0000_0000_0031);
        check("r1", rs2_data, 64'h0000_0000_0000_0001);
        rd2(6'd5, 6'd2);
        check("r5_keep", rs1_data, 64'h0000_0000_DEAD_BEEF);
        check("r2_empty", rs2_data, 64'd0);
        check("cnt_3", {48'd0, wr_count}, 64'd3);

        wr(6'd7, 64'h55);
        rd_we = 1'b1; rd_addr = 6'd7; rd_data = 64'h1234;
        rd2(6'd7, 6'd5);
`ifdef ALU_REG_FILE_BYPASS_EN
        exp_fwd = 64'h1234;
`else
        exp_fwd = 64'h55;
`endif
        check("r7_same_cycle", rs1_data, exp_fwd);
        check("r5_no_fwd", rs2_data, 64'h0000_0000_DEAD_BEEF);
        @(posedge clk);
        #1;
        rd_we = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        rd2(6'd7, 6'd7);
        check("r7_after", rs1_data, 64'h1234);
        check("r7_after_rs2", rs2_data, 64'h1234);
        check("cnt_5", {48'd0, wr_count}, 64'd5);

        rd_we = 1'b1; rd_addr = 6'd0; rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd2(6'd0, 6'd0);
        check("r0_no_fwd", rs1_data, 64'd0);
        rd_we = 1'b0;

        flag_we = 1'b1; z_f_in = 1'b1; o_f_in = 1'b0;
        @(posedge clk);
        #1;
        check("z_set", {63'd0, z_flag}, 64'd1);
        check("o_clr", {63'd0, o_flag}, 64'd0);
        flag_we = 1'b0; z_f_in = 1'b0; o_f_in = 1'b1;
        @(posedge clk);
        #1;
        check("z_hold", {63'd0, z_flag}, 64'd1);
        check("o_hold", {63'd0, o_flag}, 64'd0);
        flag_we = 1'b1; z_f_in = 1'b0; o_f_in = 1'b1;
        wr(6'd2, 64'hC0DE);
        flag_we = 1'b0;
        rd2(6'd2, 6'd2);
        check("z_both", {63'd0, z_flag}, 64'd0);
        check("o_both", {63'd0, o_flag}, 64'd1);
        check("r2_both", rs1_data, 64'hC0DE);
        check("cnt_6", {48'd0, wr_count}, {48'd0, exp_cnt});

        wr(6'd3, 64'hAA);
        rd2(6'd3, 6'd3);
        check("r3_aa", rs1_data, 64'hAA);
        rd_we = 1'b1; rd_addr = 6'd3; rd_data = 64'hBB;
        #2;
        rst_n = 1'b0;
        #1;
        check("r3_async_rst", rs1_data, 64'd0);
        check("cnt_async_rst", {48'd0, wr_count}, 64'd0);
        check("o_async_rst", {63'd0, o_flag}, 64'd0);
        @(posedge clk);
        #1;
        check("r3_rst_edge", rs1_data, 64'd0);
        check("cnt_rst_edge", {48'd0, wr_count}, 64'd0);
        #3;
        rd_addr = 6'd4; rd_data = 64'h77;
        rst_n = 1'b1;
        rd2(6'd3, 6'd4);
        check("r3_release", rs1_data, 64'd0);
        @(posedge clk);
        #1;
        rd_we = 1'b0;
        exp_cnt = 16'd1;
        rd2(6'd3, 6'd4);
        check("r3_after_rel", rs1_data, 64'd0);
        check("r4_first_wr", rs2_data, 64'h77);
        check("cnt_first_wr", {48'd0, wr_count}, 64'd1);

        rd_we = 1'b1; rd_addr = 6'd9;
        for (int i = 0; i < 65534; i++) begin
            rd_data = 64'(i);
            @(posedge clk);
            #1;
        end
        rd_we = 1'b0;
        check("cnt_ffff", {48'd0, wr_count}, 64'hFFFF);
        wr(6'd9, 64'hBEEF);
        rd2(6'd9, 6'd4);
        check("cnt_wrap", {48'd0, wr_count}, 64'd0);
        check("r9_last", rs1_data, 64'hBEEF);
        check("r4_keep", rs2_data, 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_reg_file.md
Name: alu_reg_file

Overview:
- Architectural register file that sits directly upstream and downstream of the ALU in the single-cycle datapath.
- Two combinational read ports drive the ALU operands a_in and b_in.
- One synchronous write port accepts the ALU result for writeback.
- A status register captures the ALU zero and overflow flags for later branch decisions.

Parameters:
- DATA_W, 64, register and data width; matches the ALU operand width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of implemented registers; must be ≤ 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 register 0 is writable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_data  output  DATA_W  read port 1 data; feeds ALU a_in.
- rs2_data  output  DATA_W  read port 2 data; feeds ALU b_in.
- rd_we  input  1  writeback enable.
- rd_addr  input  ADDR_W  writeback address.
- rd_data  input  DATA_W  writeback data; ALU result.
- flag_we  input  1  status register update enable.
- z_f_in  input  1  ALU zero flag.
- o_f_in  input  1  ALU overflow flag.
- z_flag  output  1  registered zero flag.
- o_flag  output  1  registered overflow flag.
- wr_count  output  16  count of committed register writes; wraps.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers, z_flag, o_flag and wr_count to 0.
  - rs1_data and rs2_data therefore read 0 while reset is held.
  - Reset asserted mid-cycle overrides any pending write; no write commits on a clock edge where rst_n is low.
  - First write can commit on the first rising edge after rst_n deasserts.
- Reads:
  - Purely combinational, zero latency.
  - rsN_data = reg[rsN_addr].
  - Address ≥ NUM_REGS reads 0.
  - With ZERO_REG=1, address 0 always reads 0.
- Writes:
  - On the rising edge with rd_we=1, reg[rd_addr] <= rd_data.
  - A write is discarded (no state change, wr_count not incremented) when:
    - rd_addr ≥ NUM_REGS, or
    - ZERO_REG=1 and rd_addr=0.
  - Otherwise wr_count increments by 1 per committed write, wrapping 0xFFFF -> 0x0000.
- Read/write same address in the same cycle: the read returns the OLD value until the edge and the new value after it (no bypass unless the optional feature is enabled).
- Both read ports addressing the same register return identical data.
- Flags:
  - On the rising edge with flag_we=1, z_flag <= z_f_in and o_flag <= o_f_in.
  - With flag_we=0 the flags hold.
  - flag_we and rd_we are independent; both may update in the same cycle.
- X-safety:
  - rd_we or flag_we = X is treated as a protocol error; the bench must not drive it.
  - Outputs must never go X after reset for known addresses.

Optional Feature:
- Macro: ALU_REG_FILE_BYPASS_EN.
- When defined:
  - If rd_we=1, the write is committable, and rsN_addr == rd_addr, then rsN_data = rd_data combinationally in the same cycle (write-through forwarding).
  - Each read port forwards independently.
  - Discarded writes (addr 0 with ZERO_REG=1, out-of-range address) are never forwarded.
- When undefined: reads always return the stored value, as described in Behaviour.

Test Plan:
- Reset, then read registers 0..31 on both ports -> all 0; z_flag=0, o_flag=0, wr_count=0.
- Write 0x0000_0000_DEAD_BEEF to r5, then read rs1=5 and rs2=5 next cycle -> both 0x0000_0000_DEAD_BEEF; wr_count=1.
- With ZERO_REG=1, write 0xFFFF_FFFF_FFFF_FFFF to r0 -> r0 reads 0, wr_count unchanged. Write r40 with ADDR_W=6, NUM_REGS=32 -> ignored.
- Same-cycle write 0x1234 to r7 while reading r7 (old value 0x55):
  - Bypass off -> 0x55 before the edge, 0x1234 after.
  - Bypass on -> 0x1234 immediately.
- Flag capture:
  - flag_we=1, z_f_in=1, o_f_in=0 -> z_flag=1, o_flag=0 after the edge.
  - Then flag_we=0 with z_f_in=0, o_f_in=1 -> flags hold at 1/0.
- Write r3=0xAA, then assert rst_n low asynchronously mid-cycle with rd_we=1 to r3=0xBB -> r3 reads 0 immediately and after release. 65536 committed writes from reset -> wr_count wraps to 0.
